char_action_arbiter: RTL and testbench

//   Turns raw left/right/jump buttons into single, well-ordered action commands for the

---
 rtl/char_action_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_char_action_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/char_action_arbiter.sv
// rtl/char_action_arbiter.sv - button-to-action command arbiter for the character physics block
// Optional walk auto-repeat is compiled in when CHAR_WALK_REPEAT_EN is defined.
module char_action_arbiter #(
  parameter int CHARGE_WIDTH    = 7,
  parameter int MAX_CHARGE      = 100,
  parameter int CHARGE_STEP     = 10,
  parameter int COOLDOWN_CYCLES = 4,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic                    character_clk,
  input  logic                    sys_rst_n,
  input  logic                    left_btn,
  input  logic                    right_btn,
  input  logic                    jump_btn,
  input  logic                    on_ground,
  input  logic                    cmd_ready,
  output logic                    cmd_valid,
  output logic [1:0]              cmd_op,
  output logic [1:0]              cmd_dir,
  output logic [CHARGE_WIDTH-1:0] cmd_charge,
  output logic [2:0]              arb_state,
  output logic                    busy
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WALK_REQ   = 3'd1,
    ST_CHARGE     = 3'd2,
    ST_LAUNCH_REQ = 3'd3,
    ST_AIRBORNE   = 3'd4,
    ST_COOLDOWN   = 3'd5
  } state_t;

  localparam logic [1:0] OP_NOP    = 2'd0;
  localparam logic [1:0] OP_WALK   = 2'd1;
  localparam logic [1:0] OP_JUMP   = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b11;
  localparam logic [1:0] DIR_UP    = 2'b00;

  localparam int CD_W = (COOLDOWN_CYCLES < 2) ? 1 : $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [CD_W-1:0]         CD_INIT  = CD_W'(COOLDOWN_CYCLES);
  localparam logic [CHARGE_WIDTH:0]   STEP_EXT = (CHARGE_WIDTH+1)'(CHARGE_STEP);
  localparam logic [CHARGE_WIDTH:0]   MAX_EXT  = (CHARGE_WIDTH+1)'(MAX_CHARGE);
  localparam logic [CHARGE_WIDTH-1:0] MAX_Q    = CHARGE_WIDTH'(MAX_CHARGE);

  state_t                  state;
  logic                    left_d, right_d, jump_d;
  logic                    left_rise, right_rise, jump_rise;
  logic [CHARGE_WIDTH-1:0] charge;
  logic [CHARGE_WIDTH:0]   charge_sum;
  logic [CHARGE_WIDTH-1:0] charge_next;
  logic [CD_W-1:0]         cd_cnt;
  logic [1:0]              dir_q;
  logic [1:0]              exit_dir;
  logic [1:0]              walk_dir;

`ifdef CHAR_WALK_REPEAT_EN
  localparam int RP_W = (REPEAT_PERIOD < 2) ? 1 : $clog2(REPEAT_PERIOD + 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_PERIOD - 1);
  logic [RP_W-1:0] rep_cnt;
`else
  logic unused_repeat_period;
  assign unused_repeat_period = (REPEAT_PERIOD != 0);
`endif

  assign left_rise  = left_btn & ~left_d;
  assign right_rise = right_btn & ~right_d;
  assign jump_rise  = jump_btn & ~jump_d;

  // One guard bit so the add cannot wrap before saturation.
  assign charge_sum  = {1'b0, charge} + STEP_EXT;
  assign charge_next = (charge_sum >= MAX_EXT) ? MAX_Q : charge_sum[CHARGE_WIDTH-1:0];

  assign exit_dir = (left_btn && !right_btn) ? DIR_LEFT :
                    (right_btn && !left_btn) ? DIR_RIGHT : DIR_UP;
  assign walk_dir = left_btn ? DIR_LEFT : DIR_RIGHT;
  assign arb_state = state;

  always_ff @(posedge character_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      left_d     <= 1'b0;
      right_d    <= 1'b0;
      jump_d     <= 1'b0;
      charge     <= '0;
      cd_cnt     <= '0;
      dir_q      <= DIR_UP;
      cmd_valid  <= 1'b0;
      cmd_op     <= OP_NOP;
      cmd_dir    <= DIR_UP;
      cmd_charge <= '0;
      busy       <= 1'b0;
`ifdef CHAR_WALK_REPEAT_EN
      rep_cnt    <= '0;
`endif
    end else begin
      left_d     <= left_btn;
      right_d    <= right_btn;
      jump_d     <= jump_btn;
      // Outputs default to an idle bus; states holding a command re-assert it.
      cmd_valid  <= 1'b0;
      cmd_op     <= OP_NOP;
      cmd_dir    <= DIR_UP;
      cmd_charge <= '0;
      busy       <= 1'b1;
`ifdef CHAR_WALK_REPEAT_EN
      rep_cnt    <= '0;
`endif
      case (state)
        ST_IDLE: begin
          if (!on_ground) begin
            state <= ST_AIRBORNE;
          end else if (jump_rise) begin
            state  <= ST_CHARGE;
            charge <= '0;
          end else if (left_rise != right_rise) begin
            state     <= ST_WALK_REQ;
            dir_q     <= left_rise ? DIR_LEFT : DIR_RIGHT;
            cmd_valid <= 1'b1;
            cmd_op    <= OP_WALK;
            cmd_dir   <= left_rise ? DIR_LEFT : DIR_RIGHT;
          end else begin
            busy <= 1'b0;
`ifdef CHAR_WALK_REPEAT_EN
            if (!left_rise && !right_rise && (left_btn ^ right_btn)) begin
              if (rep_cnt == RP_LAST) begin
                state     <= ST_WALK_REQ;
                dir_q     <= walk_dir;
                cmd_valid <= 1'b1;
                cmd_op    <= OP_WALK;
                cmd_dir   <= walk_dir;
                busy      <= 1'b1;
              end else begin
                rep_cnt <= rep_cnt + 1'b1;
              end
            end
`endif
          end
        end
        ST_WALK_REQ: begin
          if (!on_ground) begin
            state <= ST_AIRBORNE;
          end else if (cmd_ready) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cmd_valid <= 1'b1;
            cmd_op    <= OP_WALK;
            cmd_dir   <= dir_q;
          end
        end
        ST_CHARGE: begin
          if (!on_ground) begin
            state  <= ST_AIRBORNE;
            charge <= '0;
          end else if (!jump_btn || charge == MAX_Q) begin
            state      <= ST_LAUNCH_REQ;
            dir_q      <= exit_dir;
            cmd_valid  <= 1'b1;
            cmd_op     <= OP_JUMP;
            cmd_dir    <= exit_dir;
            cmd_charge <= charge;
          end else begin
            charge <= charge_next;
          end
        end
        ST_LAUNCH_REQ: begin
          if (cmd_ready) begin
            state  <= ST_AIRBORNE;
            charge <= '0;
          end else begin
            cmd_valid  <= 1'b1;
            cmd_op     <= OP_JUMP;
            cmd_dir    <= dir_q;
            cmd_charge <= charge;
          end
        end
        ST_AIRBORNE: begin
          if (on_ground) begin
            if (COOLDOWN_CYCLES == 0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state  <= ST_COOLDOWN;
              cd_cnt <= CD_INIT;
            end
          end
        end
        ST_COOLDOWN: begin
          if (!on_ground) begin
            state <= ST_AIRBORNE;
          end else if (cd_cnt <= CD_W'(1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cd_cnt <= cd_cnt - 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          charge <= '0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_char_action_arbiter.sv
// tb/tb_char_action_arbiter.sv - directed bench with a mode-level model of char_action_arbiter
module tb_char_action_arbiter;

  localparam int CW   = 7;
  localparam int MAXC = 100;
  localparam int STEP = 10;
  localparam int CD   = 4;
  localparam int RP   = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          l = 1'b0, r = 1'b0, j = 1'b0, g = 1'b1, rdy = 1'b1;
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic [1:0]    cmd_dir;
  logic [CW-1:0] cmd_charge;
  logic [2:0]    arb_state;
  logic          busy;

  always #5 clk = ~clk;

  char_action_arbiter #(
    .CHARGE_WIDTH(CW), .MAX_CHARGE(MAXC), .CHARGE_STEP(STEP),
    .COOLDOWN_CYCLES(CD), .REPEAT_PERIOD(RP)
  ) dut (
    .character_clk(clk), .sys_rst_n(rst_n),
    .left_btn(l), .right_btn(r), .jump_btn(j), .on_ground(g), .cmd_ready(rdy),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_dir(cmd_dir), .cmd_charge(cmd_charge),
    .arb_state(arb_state), .busy(busy)
  );

  int total = 0;
  int bad = 0;

  // Model: mode number, charge counted as number of increments, direction as signed int.
  int m_mode, m_held, m_dir, m_cd;
  bit m_pl, m_pr, m_pj;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_charge();
    return (m_held * STEP > MAXC) ? MAXC : m_held * STEP;
  endfunction

  function automatic int enc_dir(input int d);
    return (d == 1) ? 1 : (d == -1) ? 3 : 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_held = 0; m_dir = 0; m_cd = 0;
    m_pl = 0; m_pr = 0; m_pj = 0;
  endtask

  task automatic model_step();
    bit lr, rr, jr;
    if (!rst_n) begin
      model_reset();
      return;
    end
    lr = l && !m_pl;
    rr = r && !m_pr;
    jr = j && !m_pj;
    case (m_mode)
      0: if (!g) m_mode = 4;
         else if (jr) begin m_mode = 2; m_held = 0; end
         else if (lr && !rr) begin m_mode = 1; m_dir = 1; end
         else if (rr && !lr) begin m_mode = 1; m_dir = -1; end
      1: if (!g) m_mode = 4;
         else if (rdy) m_mode = 0;
      2: if (!g) begin m_mode = 4; m_held = 0; end
         else if (!j || exp_charge() == MAXC) begin
           m_mode = 3;
           m_dir = (l && !r) ? 1 : (r && !l) ? -1 : 0;
         end else m_held++;
      3: if (rdy) begin m_mode = 4; m_held = 0; end
      4: if (g) begin m_mode = (CD == 0) ? 0 : 5; m_cd = CD; end
      5: if (!g) m_mode = 4;
         else if (m_cd == 1) m_mode = 0;
         else m_cd--;
      default: m_mode = 0;
    endcase
    m_pl = l; m_pr = r; m_pj = j;
  endtask

  initial model_reset();

  // Compare process: every negedge, DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("valid", int'(cmd_valid), (m_mode == 1 || m_mode == 3) ? 1 : 0);
      chk("op", int'(cmd_op), (m_mode == 1) ? 1 : (m_mode == 3) ? 2 : 0);
      chk("dir", int'(cmd_dir), (m_mode == 1 || m_mode == 3) ? enc_dir(m_dir) : 0);
      chk("charge", int'(cmd_charge), (m_mode == 3) ? exp_charge() : 0);
      chk("state", int'(arb_state), m_mode);
      chk("busy", int'(busy), (m_mode != 0) ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  int vcnt, first_launch, launch_charge, launch_dir, cool_cnt;

  initial begin
    // Reset, then 5 quiet cycles.
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_valid", int'(cmd_valid), 0);
      chk("rst_state", int'(arb_state), 0);
      chk("rst_busy", int'(busy), 0);
    end

    // Left pulse walk, ready high.
    l = 1; tick();
    chk("walk_l_valid", int'(cmd_valid), 1);
    chk("walk_l_op", int'(cmd_op), 1);
    chk("walk_l_dir", int'(cmd_dir), 1);
    l = 0; tick();
    chk("walk_l_done", int'(cmd_valid), 0);
    chk("walk_l_idle", int'(arb_state), 0);

    // Right pulse walk.
    r = 1; tick();
    chk("walk_r_dir", int'(cmd_dir), 3);
    r = 0; tick();

    // Three charge cycles, release with right held, ready low two cycles.
    j = 1; rdy = 0; tick();
    chk("charge_enter", int'(arb_state), 2);
    repeat (3) tick();
    j = 0; r = 1; tick();
    vcnt = int'(cmd_valid);
    chk("launch30_op", int'(cmd_op), 2);
    chk("launch30_dir", int'(cmd_dir), 3);
    chk("launch30_charge", int'(cmd_charge), 30);
    repeat (2) begin tick(); vcnt += int'(cmd_valid); end
    rdy = 1; tick();
    chk("launch30_vcnt", vcnt, 3);
    chk("launch30_air", int'(arb_state), 4);
    r = 0;
    repeat (8) tick();

    // Jump held 20 cycles: saturates and launches once.
    j = 1; first_launch = 0; launch_charge = -1; launch_dir = -1; vcnt = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (cmd_valid) begin
        vcnt++;
        if (first_launch == 0) begin
          first_launch = i; launch_charge = int'(cmd_charge); launch_dir = int'(cmd_dir);
        end
      end
    end
    chk("sat_cycle", first_launch, 12);
    chk("sat_charge", launch_charge, 100);
    chk("sat_dir", launch_dir, 0);
    chk("sat_count", vcnt, 1);
    j = 0;
    repeat (8) tick();

    // Quick launch, 6 airborne cycles with left pulses, landing, cooldown with a left pulse.
    j = 1; tick();
    j = 0; tick();
    g = 0; tick();
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      l = i[0]; tick(); vcnt += int'(cmd_valid);
    end
    chk("air_state", int'(arb_state), 4);
    l = 0; g = 1; tick();
    cool_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (arb_state == 3'd5) cool_cnt++;
      vcnt += int'(cmd_valid);
      l = (k == 0); tick();
    end
    l = 0;
    chk("cool_cycles", cool_cnt, 4);
    chk("air_cool_nocmd", vcnt, 0);
    chk("cool_idle", int'(arb_state), 0);

    // on_ground drops during charge.
    j = 1; tick(); tick();
    g = 0; tick();
    chk("drop_state", int'(arb_state), 4);
    chk("drop_valid", int'(cmd_valid), 0);
    j = 0; g = 1;
    repeat (6) tick();
    chk("drop_idle", int'(arb_state), 0);

    // Simultaneous left+right edge is ignored; jump beats walk.
    l = 1; r = 1; tick();
    chk("lr_valid", int'(cmd_valid), 0);
    chk("lr_state", int'(arb_state), 0);
    l = 0; r = 0; tick();
    l = 1; j = 1; tick();
    chk("jump_beats_walk", int'(arb_state), 2);
    l = 0; j = 0; rdy = 1;
    repeat (8) tick();

    // Reset while a walk command waits for ready.
    l = 1; rdy = 0; tick();
    chk("pre_rst_valid", int'(cmd_valid), 1);
    rst_n = 1'b0; model_reset(); #1;
    chk("mid_rst_valid", int'(cmd_valid), 0);
    chk("mid_rst_state", int'(arb_state), 0);
    tick();
    l = 0; rdy = 1; rst_n = 1'b1;
    repeat (2) tick();
    chk("post_rst_state", int'(arb_state), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
